// File: rtl/wb_gpio_pkg.sv
// Shared definitions for wb_gpio: register word offsets, transaction FSM
// encoding and the byte-lane mask helper.
package wb_gpio_pkg;

  localparam logic [2:0] GPIO_OUT      = 3'd0;
  localparam logic [2:0] GPIO_DIR      = 3'd1;
  localparam logic [2:0] GPIO_IN       = 3'd2;
  localparam logic [2:0] GPIO_IRQ_MASK = 3'd3;
  localparam logic [2:0] GPIO_IRQ_STAT = 3'd4;
  localparam logic [2:0] GPIO_EDGE     = 3'd5;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_RESP = 1'b1
  } wb_state_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// WIDTH-bit two-flop synchronizer with asynchronous active-low reset,
// usable by any peripheral sampling asynchronous pads.
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/wb_gpio.sv
// Wishbone GPIO slave: output/direction registers, synchronized input and,
// when WB_GPIO_IRQ_EN is defined, per-pin edge interrupts with W1C status.
//
// state   | meaning
// WB_IDLE | waiting for cyc & stb; access performed on the accepting edge
// WB_RESP | ack or err high for this single cycle, new strobes ignored
module wb_gpio
  import wb_gpio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic [31:0]      i_wb_addr,
  input  logic [31:0]      i_wb_data,
  input  logic [3:0]       i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_data,
  output logic             o_wb_stall,
  output logic             o_wb_err,
  inout  wire  [WIDTH-1:0] io_gpio,
  output logic             o_irq
);

  wb_state_e        state_q, state_d;
  logic             accept, mapped, wr_en;
  logic [2:0]       offset;
  logic [31:0]      lanes, rdata;
  logic [WIDTH-1:0] wmask, wdata, out_q, dir_q, in_sync;
  logic             unused_bits;

  assign offset      = i_wb_addr[4:2];
  assign lanes       = lane_mask(i_wb_sel);
  assign wmask       = lanes[WIDTH-1:0];
  assign wdata       = i_wb_data[WIDTH-1:0];
  assign wr_en       = accept & i_wb_we & mapped;
  assign o_wb_stall  = 1'b0;
  assign unused_bits = ^{i_wb_addr[31:5], i_wb_addr[1:0], i_wb_data, lanes};

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign io_gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  // Pads are sampled regardless of direction, so driven pins read back.
  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (i_clk),
    .rst_n (i_resetn),
    .d     (io_gpio),
    .q     (in_sync)
  );

`ifdef WB_GPIO_IRQ_EN
  logic [WIDTH-1:0] prev_q, mask_q, stat_q, edge_q, irq_evt, stat_clr;

  assign irq_evt  = (edge_q & in_sync & ~prev_q) | (~edge_q & ~in_sync & prev_q);
  assign stat_clr = (wr_en && offset == GPIO_IRQ_STAT) ? (wdata & wmask) : '0;
  assign o_irq    = |(stat_q & mask_q);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      prev_q <= '0;
      mask_q <= '0;
      stat_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= in_sync;
      // A new event outranks a same-cycle clear of the same bit.
      stat_q <= (stat_q & ~stat_clr) | irq_evt;
      if (wr_en && offset == GPIO_IRQ_MASK) mask_q <= (mask_q & ~wmask) | (wdata & wmask);
      if (wr_en && offset == GPIO_EDGE)     edge_q <= (edge_q & ~wmask) | (wdata & wmask);
    end
  end
`else
  assign o_irq = 1'b0;
`endif

  always_comb begin
    mapped = 1'b1;
    rdata  = 32'd0;
    case (offset)
      GPIO_OUT:      rdata = 32'(out_q);
      GPIO_DIR:      rdata = 32'(dir_q);
      GPIO_IN:       rdata = 32'(in_sync);
`ifdef WB_GPIO_IRQ_EN
      GPIO_IRQ_MASK: rdata = 32'(mask_q);
      GPIO_IRQ_STAT: rdata = 32'(stat_q);
      GPIO_EDGE:     rdata = 32'(edge_q);
`endif
      default:       mapped = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) state_q <= WB_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          accept  = 1'b1;
          state_d = WB_RESP;
        end
      end
      WB_RESP: state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= 32'd0;
    end else begin
      o_wb_ack  <= accept & mapped;
      o_wb_err  <= accept & ~mapped;
      o_wb_data <= (accept & mapped) ? rdata : 32'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      out_q <= '0;
      dir_q <= '0;
    end else if (wr_en) begin
      if (offset == GPIO_OUT) out_q <= (out_q & ~wmask) | (wdata & wmask);
      if (offset == GPIO_DIR) dir_q <= (dir_q & ~wmask) | (wdata & wmask);
    end
  end

endmodule
